// File: rtl/pixel_packer_axis.sv
// Packs ISIZE-bit pixels into OSIZE-bit words through a bit-level accumulator,
// with valid/ready backpressure, line-start realignment and a strobed last-beat flush.
module pixel_packer_axis #(
  parameter int ISIZE     = 24,
  parameter int OSIZE     = 256,
  parameter int MSB_FIRST = 1
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [ISIZE-1:0]   s_data,
  input  logic               s_align,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OSIZE-1:0]   m_data,
  output logic [OSIZE/8-1:0] m_strb,
  output logic               m_last,
  output logic               err_align
);

  localparam int ACCW = OSIZE + ISIZE;
  localparam int FW   = $clog2(ACCW);
  localparam int NB   = OSIZE / 8;

  localparam logic [FW-1:0] OSIZE_F = FW'(OSIZE);
  localparam logic [FW-1:0] ISIZE_F = FW'(ISIZE);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [ACCW-1:0]  acc_q, acc_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [0:0]       state_q, state_d;
  logic             m_valid_q, m_valid_d;
  logic [OSIZE-1:0] m_data_q, m_data_d;
  logic [NB-1:0]    m_strb_q, m_strb_d;
  logic             m_last_q, m_last_d;
  logic             err_q, err_d;

  logic             out_free;
  logic             accept;
  logic [ACCW-1:0]  base_acc;
  logic [FW-1:0]    base_fill;
  logic [ACCW-1:0]  pix_shift;
  logic [ACCW-1:0]  merged;
  logic [FW-1:0]    total;

  // Held bits are kept packed against the output word's first-pixel end, so
  // the next word is always a fixed slice and the residual a fixed shift.
  function automatic logic [OSIZE-1:0] word_of(input logic [ACCW-1:0] a);
    if (MSB_FIRST != 0) word_of = a[ACCW-1 -: OSIZE];
    else                word_of = a[OSIZE-1:0];
  endfunction

  function automatic logic [ACCW-1:0] rest_of(input logic [ACCW-1:0] a);
    if (MSB_FIRST != 0) rest_of = a << OSIZE;
    else                rest_of = a >> OSIZE;
  endfunction

  function automatic logic [NB-1:0] strb_for(input logic [FW-1:0] bits);
    logic [FW-1:0] nbytes;
    logic [NB-1:0] ones;
    nbytes = (bits + FW'(7)) >> 3;
    ones   = '1;
    if (MSB_FIRST != 0) strb_for = ~(ones >> nbytes);
    else                strb_for = ~(ones << nbytes);
  endfunction

  assign out_free  = ~m_valid_q | m_ready;
  assign s_ready   = (state_q == ST_RUN) & out_free;
  assign accept    = s_valid & s_ready;
  assign base_acc  = s_align ? '0 : acc_q;
  assign base_fill = s_align ? '0 : fill_q;
  assign total     = base_fill + ISIZE_F;

  always_comb begin
    if (MSB_FIRST != 0) pix_shift = {s_data, {OSIZE{1'b0}}} >> base_fill;
    else                pix_shift = ACCW'(s_data) << base_fill;
    merged = base_acc | pix_shift;
  end

  // Loads only happen when the output stage is free, so a stalled word is never touched.
  always_comb begin
    acc_d     = acc_q;
    fill_d    = fill_q;
    state_d   = state_q;
    m_valid_d = m_valid_q & ~m_ready;
    m_data_d  = m_data_q;
    m_strb_d  = m_strb_q;
    m_last_d  = m_last_q;
    err_d     = 1'b0;

    if (accept) begin
      err_d = s_align & (fill_q != '0);
      if (total >= OSIZE_F) begin
        m_valid_d = 1'b1;
        m_data_d  = word_of(merged);
        m_strb_d  = '1;
        m_last_d  = s_last & (total == OSIZE_F);
        acc_d     = rest_of(merged);
        fill_d    = total - OSIZE_F;
        if (s_last && (total != OSIZE_F)) state_d = ST_FLUSH;
      end else if (s_last) begin
        m_valid_d = 1'b1;
        m_data_d  = word_of(merged);
        m_strb_d  = strb_for(total);
        m_last_d  = 1'b1;
        acc_d     = '0;
        fill_d    = '0;
      end else begin
        acc_d  = merged;
        fill_d = total;
      end
    end else if ((state_q == ST_FLUSH) && out_free) begin
      m_valid_d = 1'b1;
      m_data_d  = word_of(acc_q);
      m_strb_d  = strb_for(fill_q);
      m_last_d  = 1'b1;
      acc_d     = '0;
      fill_d    = '0;
      state_d   = ST_RUN;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      fill_q    <= '0;
      state_q   <= ST_RUN;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_strb_q  <= '0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_strb_q  <= m_strb_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_strb    = m_strb_q;
  assign m_last    = m_last_q;
  assign err_align = err_q;

endmodule

// File: tb/tb_pixel_packer_axis.sv
// Scoreboard bench for pixel_packer_axis: a bit-list model predicts every output
// word when a beat is accepted; a negedge monitor pops and compares on each handshake.
module tb_pixel_packer_axis;

  logic         clock;
  logic         rst_n;
  logic         s_valid, s_ready, s_align, s_last;
  logic [23:0]  s_data;
  logic         m_valid, m_ready, m_last, err_align;
  logic [255:0] m_data;
  logic [31:0]  m_strb;

  logic         l_s_valid, l_s_ready, l_s_align, l_s_last;
  logic [23:0]  l_s_data;
  logic         l_m_valid, l_m_ready, l_m_last, l_err_align;
  logic [255:0] l_m_data;
  logic [31:0]  l_m_strb;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
  } word_t;

  word_t exp_q[$];
  bit    pend[$];
  int    compared  = 0;
  int    failed    = 0;
  int    exp_err   = 0;
  int    err_seen  = 0;
  int    words_seen = 0;

  pixel_packer_axis #(.ISIZE(24), .OSIZE(256), .MSB_FIRST(1)) dut (
    .clock(clock), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_align(s_align), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_strb(m_strb), .m_last(m_last), .err_align(err_align)
  );

  pixel_packer_axis #(.ISIZE(24), .OSIZE(256), .MSB_FIRST(0)) dut_lsb (
    .clock(clock), .rst_n(rst_n),
    .s_valid(l_s_valid), .s_ready(l_s_ready), .s_data(l_s_data),
    .s_align(l_s_align), .s_last(l_s_last),
    .m_valid(l_m_valid), .m_ready(l_m_ready), .m_data(l_m_data),
    .m_strb(l_m_strb), .m_last(l_m_last), .err_align(l_err_align)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic emit_word(input int n, input bit lst);
    word_t w;
    w.data = '0;
    w.strb = '0;
    for (int i = 0; i < n; i++) w.data[255-i] = pend.pop_front();
    for (int b = 0; b < (n + 7) / 8; b++) w.strb[31-b] = 1'b1;
    w.last = lst;
    exp_q.push_back(w);
  endtask

  task automatic model_beat(input logic [23:0] d, input bit align, input bit last);
    if (align) begin
      if (pend.size() != 0) exp_err++;
      pend.delete();
    end
    for (int i = 23; i >= 0; i--) pend.push_back(d[i]);
    if (pend.size() >= 256) emit_word(256, last && (pend.size() == 256));
    if (last && (pend.size() > 0)) emit_word(pend.size(), 1'b1);
  endtask

  always @(negedge clock) begin
    if (rst_n) begin
      if (err_align) err_seen++;
      if (m_valid && m_ready) begin
        word_t w;
        words_seen++;
        compared++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("[TB] FAIL unexpected_word: got data=%h, expected no word", m_data);
        end else begin
          w = exp_q.pop_front();
          if (m_data !== w.data) begin
            failed++;
            $display("[TB] FAIL word_data: got %h, expected %h", m_data, w.data);
          end
          compared++;
          if (m_strb !== w.strb) begin
            failed++;
            $display("[TB] FAIL word_strb: got %h, expected %h", m_strb, w.strb);
          end
          compared++;
          if (m_last !== w.last) begin
            failed++;
            $display("[TB] FAIL word_last: got %b, expected %b", m_last, w.last);
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send_pixel(input logic [23:0] d, input bit align, input bit last);
    bit got;
    got = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_align = align;
    s_last  = last;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clock);
      if (s_ready) begin
        model_beat(d, align, last);
        got = 1;
      end
    end
    if (!got) begin
      compared++;
      failed++;
      $display("[TB] FAIL send_timeout: s_ready=%b, expected 1 within 200 cycles", s_ready);
    end
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    s_align = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clock);
    repeat (4) @(negedge clock);
    compared++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("[TB] FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({m_valid, m_data, m_strb, m_last, err_align} !== '0) begin
      failed++;
      $display("[TB] FAIL reset_outputs: got valid=%b strb=%h last=%b err=%b, expected all 0",
               m_valid, m_strb, m_last, err_align);
    end
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    @(negedge clock);
    compared++;
    if (s_ready !== 1'b1) begin
      failed++;
      $display("[TB] FAIL reset_s_ready: got %b, expected 1", s_ready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_exact_fit;
    int w0;
    w0 = words_seen;
    m_ready = 1'b1;
    for (int p = 1; p <= 32; p++) send_pixel(24'(p), 1'b0, p == 32);
    drain("exact_fit");
    compared++;
    if (words_seen - w0 != 3) begin
      failed++;
      $display("[TB] FAIL exact_fit_count: got %0d words, expected 3", words_seen - w0);
    end
  endtask

  task automatic test_overflow_flush;
    m_ready = 1'b1;
    for (int p = 0; p < 11; p++) send_pixel(24'hAAAAAA, 1'b0, p == 10);
    @(negedge clock);
    compared++;
    if (s_ready !== 1'b0) begin
      failed++;
      $display("[TB] FAIL flush_ready_low: got %b, expected 0", s_ready);
    end
    @(negedge clock);
    compared++;
    if (s_ready !== 1'b1) begin
      failed++;
      $display("[TB] FAIL flush_ready_back: got %b, expected 1", s_ready);
    end
    @(posedge clock);
    #1;
    drain("overflow_flush");
  endtask

  task automatic test_short_last;
    m_ready = 1'b1;
    send_pixel(24'h123456, 1'b0, 1'b0);
    send_pixel(24'h789ABC, 1'b0, 1'b0);
    send_pixel(24'hDEF012, 1'b0, 1'b1);
    drain("short_last");
  endtask

  task automatic test_lsb_first;
    logic [23:0]  pix [3];
    logic [255:0] exp_data;
    bit           got;
    pix[0] = 24'hA1B2C3;
    pix[1] = 24'hD4E5F6;
    pix[2] = 24'h071829;
    exp_data = 256'(pix[0]) | (256'(pix[1]) << 24) | (256'(pix[2]) << 48);
    for (int p = 0; p < 3; p++) begin
      l_s_valid = 1'b1;
      l_s_data  = pix[p];
      l_s_last  = (p == 2);
      got = 0;
      for (int c = 0; c < 50 && !got; c++) begin
        @(negedge clock);
        got = l_s_ready;
      end
      @(posedge clock);
      #1;
    end
    l_s_valid = 1'b0;
    l_s_last  = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clock);
      got = l_m_valid;
    end
    compared++;
    if (!got || l_m_data !== exp_data) begin
      failed++;
      $display("[TB] FAIL lsb_data: got %h, expected %h", l_m_data, exp_data);
    end
    compared++;
    if (l_m_strb !== 32'h0000_01FF || l_m_last !== 1'b1) begin
      failed++;
      $display("[TB] FAIL lsb_strb_last: got %h/%b, expected 000001ff/1", l_m_strb, l_m_last);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_backpressure;
    int w0;
    w0 = words_seen;
    m_ready = 1'b0;
    for (int p = 1; p <= 11; p++) send_pixel(24'h100000 + 24'(p), 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = 24'h10000C;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      compared++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
        failed++;
        $display("[TB] FAIL stall_ready: got s_ready=%b m_valid=%b, expected 0/1", s_ready, m_valid);
      end
      compared++;
      if (exp_q.size() == 0 || m_data !== exp_q[0].data || m_strb !== exp_q[0].strb) begin
        failed++;
        $display("[TB] FAIL stall_hold: got %h, expected pending word held", m_data);
      end
    end
    @(posedge clock);
    #1;
    m_ready = 1'b1;
    send_pixel(24'h10000C, 1'b0, 1'b0);
    for (int p = 13; p <= 32; p++) send_pixel(24'h100000 + 24'(p), 1'b0, p == 32);
    drain("backpressure");
    compared++;
    if (words_seen - w0 != 3) begin
      failed++;
      $display("[TB] FAIL backpressure_count: got %0d words, expected 3", words_seen - w0);
    end
  endtask

  task automatic test_realign;
    int e0;
    e0 = err_seen;
    m_ready = 1'b1;
    for (int p = 0; p < 5; p++) send_pixel(24'h111111 * 24'(p + 1), 1'b0, 1'b0);
    send_pixel(24'hABCDEF, 1'b1, 1'b0);
    for (int p = 0; p < 10; p++) send_pixel(24'h200000 + 24'(p), 1'b0, p == 9);
    drain("realign");
    compared++;
    if (err_seen - e0 != 1) begin
      failed++;
      $display("[TB] FAIL realign_err: got %0d pulses, expected 1", err_seen - e0);
    end
  endtask

  task automatic test_reset_midstream;
    int w0;
    m_ready = 1'b0;
    for (int p = 0; p < 11; p++) send_pixel(24'h5A5A00 + 24'(p), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({m_valid, m_data, m_strb, m_last, err_align} !== '0) begin
      failed++;
      $display("[TB] FAIL midreset_outputs: got valid=%b strb=%h last=%b, expected all 0",
               m_valid, m_strb, m_last);
    end
    exp_q.delete();
    pend.delete();
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    w0 = words_seen;
    for (int p = 1; p <= 32; p++) send_pixel(24'hC00000 + 24'(p), 1'b0, p == 32);
    drain("reset_midstream");
    compared++;
    if (words_seen - w0 != 3) begin
      failed++;
      $display("[TB] FAIL midreset_count: got %0d words, expected 3", words_seen - w0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_align = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    l_s_valid = 1'b0; l_s_data = '0; l_s_align = 1'b0; l_s_last = 1'b0; l_m_ready = 1'b1;
    test_reset();
    test_exact_fit();
    test_overflow_flush();
    test_short_last();
    test_lsb_first();
    test_backpressure();
    test_realign();
    test_reset_midstream();
    compared++;
    if (err_seen != exp_err) begin
      failed++;
      $display("[TB] FAIL err_total: got %0d pulses, expected %0d", err_seen, exp_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
